// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. MDU results, with MDU starvation forcing.
// Optional perf counters (conflict_cnt, force_cnt) are enabled by defining WB_ARB_PERF_EN.
module wb_port_arbiter #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_dst,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_ready,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_dst,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef WB_ARB_PERF_EN
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       force_cnt,
`endif
    output logic [3:0]        starve_cnt
);

    // state     | meaning
    // NORMAL    | pipeline has priority for the write port
    // FORCE_MDU | MDU waited STARVE_LIMIT cycles and now has priority
    typedef enum logic {NORMAL, FORCE_MDU} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_starve;
    logic [3:0]        w_starve_nxt;
    logic              w_pipe_eff;
    logic              w_mdu_eff;
    logic              w_pipe_wr;
    logic              w_mdu_wr;
    logic              r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    assign w_pipe_eff = pipe_valid && (pipe_dst != '0);
    assign w_mdu_eff  = mdu_valid  && (mdu_dst  != '0);

    always_comb begin
        pipe_ready   = 1'b0;
        mdu_ready    = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (!reset) begin
            // x0 requests never occupy the port, so they are always accepted
            if (r_state == NORMAL) begin
                pipe_ready = pipe_valid;
                mdu_ready  = mdu_valid && (!w_mdu_eff || !w_pipe_eff);
            end else begin
                mdu_ready  = mdu_valid;
                pipe_ready = pipe_valid && (!w_pipe_eff || !w_mdu_eff);
            end

            if (!mdu_valid || mdu_ready)
                w_starve_nxt = 4'd0;
            else if (r_starve < LIMIT)
                w_starve_nxt = r_starve + 4'd1;

            if (r_state == NORMAL) begin
                if (w_starve_nxt == LIMIT)
                    w_state_nxt = FORCE_MDU;
            end else if (!mdu_valid || mdu_ready) begin
                w_state_nxt = NORMAL;
            end
        end
    end

    assign w_pipe_wr = pipe_ready && w_pipe_eff;
    assign w_mdu_wr  = mdu_ready  && w_mdu_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= NORMAL;
            r_starve <= 4'd0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_wen    <= w_pipe_wr || w_mdu_wr;
            if (w_pipe_wr) begin
                r_waddr <= pipe_dst;
                r_wdata <= pipe_data;
            end else if (w_mdu_wr) begin
                r_waddr <= mdu_dst;
                r_wdata <= mdu_data;
            end
        end
    end

    assign rf_wen     = r_wen;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign starve_cnt = r_starve;

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_conflict;
    logic [31:0] r_force;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict <= '0;
            r_force    <= '0;
        end else begin
            if (w_pipe_eff && w_mdu_eff)
                r_conflict <= r_conflict + 32'd1;
            if (r_state == NORMAL && w_state_nxt == FORCE_MDU)
                r_force <= r_force + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict;
    assign force_cnt    = r_force;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (STARVE_LIMIT=4), plus a hand-written FORCE_MDU drop sequence.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, mdu_valid;
    logic [4:0]  pipe_dst, mdu_dst;
    logic [63:0] pipe_data, mdu_data;
    logic        pipe_ready, mdu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  starve_cnt;
`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_cnt, force_cnt;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(64), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_dst(pipe_dst), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
        .mdu_valid(mdu_valid), .mdu_dst(mdu_dst), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_ARB_PERF_EN
        .conflict_cnt(conflict_cnt), .force_cnt(force_cnt),
`endif
        .starve_cnt(starve_cnt)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [4:0]  pd;
        logic [63:0] pdat;
        logic        mv;
        logic [4:0]  md;
        logic [63:0] mdat;
        logic        e_pr;
        logic        e_mr;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[16];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic pv, input logic [4:0] pd, input logic [63:0] pdat,
                         input logic mv, input logic [4:0] md, input logic [63:0] mdat);
        reset = rst; pipe_valid = pv; pipe_dst = pd; pipe_data = pdat;
        mdu_valid = mv; mdu_dst = md; mdu_data = mdat;
    endtask

    function automatic vec_t mk(input logic rst, input logic pv, input logic [4:0] pd, input logic [63:0] pdat,
                                input logic mv, input logic [4:0] md, input logic [63:0] mdat,
                                input logic pr, input logic mr, input logic wen, input logic [4:0] a,
                                input logic [63:0] d, input logic [3:0] c);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pd = pd; v.pdat = pdat; v.mv = mv; v.md = md; v.mdat = mdat;
        v.e_pr = pr; v.e_mr = mr; v.e_wen = wen; v.e_addr = a; v.e_data = d; v.e_cnt = c;
        return v;
    endfunction

    initial begin
        //           rst pv pd  pdat     mv md  mdat     pr mr wen addr data     cnt
        vecs[0]  = mk(1, 1, 5, 64'h1234, 1, 7, 64'h7777, 0, 0, 0,  0, 64'h0,    0);
        vecs[1]  = mk(0, 1, 5, 64'h1234, 0, 0, 64'h0,    1, 0, 1,  5, 64'h1234, 0);
        vecs[2]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0,  5, 64'h1234, 0);
        vecs[3]  = mk(0, 1, 3, 64'hAAAA, 1, 7, 64'h7777, 1, 0, 1,  3, 64'hAAAA, 1);
        vecs[4]  = mk(0, 1, 3, 64'hAAAA, 1, 7, 64'h7777, 1, 0, 1,  3, 64'hAAAA, 2);
        vecs[5]  = mk(0, 1, 3, 64'hAAAA, 1, 7, 64'h7777, 1, 0, 1,  3, 64'hAAAA, 3);
        vecs[6]  = mk(0, 1, 3, 64'hAAAA, 1, 7, 64'h7777, 1, 0, 1,  3, 64'hAAAA, 4);
        vecs[7]  = mk(0, 1, 3, 64'hAAAA, 1, 7, 64'h7777, 0, 1, 1,  7, 64'h7777, 0);
        vecs[8]  = mk(0, 1, 3, 64'hAAAA, 0, 0, 64'h0,    1, 0, 1,  3, 64'hAAAA, 0);
        vecs[9]  = mk(0, 1, 0, 64'hDEAD, 1, 9, 64'h9999, 1, 1, 1,  9, 64'h9999, 0);
        vecs[10] = mk(0, 1, 0, 64'hBEEF, 1, 0, 64'hCAFE, 1, 1, 0,  9, 64'h9999, 0);
        vecs[11] = mk(0, 1, 4, 64'h44,   1, 6, 64'h66,   1, 0, 1,  4, 64'h44,   1);
        vecs[12] = mk(0, 1, 4, 64'h44,   1, 6, 64'h66,   1, 0, 1,  4, 64'h44,   2);
        vecs[13] = mk(1, 1, 4, 64'h44,   1, 6, 64'h66,   0, 0, 0,  0, 64'h0,    0);
        vecs[14] = mk(0, 1, 4, 64'h44,   1, 6, 64'h66,   1, 0, 1,  4, 64'h44,   1);
        vecs[15] = mk(0, 0, 0, 64'h0,    1, 2, 64'h22,   0, 1, 1,  2, 64'h22,   0);

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wen", -1, {63'd0, rf_wen}, 64'd0);
        chk("reset_cnt", -1, {60'd0, starve_cnt}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].pv, vecs[i].pd, vecs[i].pdat, vecs[i].mv, vecs[i].md, vecs[i].mdat);
            #3;
            chk("pipe_ready", i, {63'd0, pipe_ready}, {63'd0, vecs[i].e_pr});
            chk("mdu_ready",  i, {63'd0, mdu_ready},  {63'd0, vecs[i].e_mr});
            @(posedge clk);
            #1;
            chk("rf_wen",     i, {63'd0, rf_wen},     {63'd0, vecs[i].e_wen});
            chk("rf_waddr",   i, {59'd0, rf_waddr},   {59'd0, vecs[i].e_addr});
            chk("rf_wdata",   i, rf_wdata,            vecs[i].e_data);
            chk("starve_cnt", i, {60'd0, starve_cnt}, {60'd0, vecs[i].e_cnt});
`ifdef WB_ARB_PERF_EN
            if (i == 7) begin
                chk("conflict_cnt", i, {32'd0, conflict_cnt}, 64'd5);
                chk("force_cnt",    i, {32'd0, force_cnt},    64'd1);
            end
`endif
        end

        // Stall MDU into FORCE_MDU, then drop mdu_valid: arbiter must return to NORMAL.
        drive(0, 1, 8, 64'h88, 1, 10, 64'hA0);
        repeat (4) @(posedge clk);
        #1;
        chk("force_cnt4", 100, {60'd0, starve_cnt}, 64'd4);
        drive(0, 1, 8, 64'h88, 0, 0, 64'h0);
        #3;
        chk("force_drop_pr", 100, {63'd0, pipe_ready}, 64'd1);
        @(posedge clk);
        #1;
        drive(0, 1, 8, 64'h88, 1, 10, 64'hA0);
        #3;
        chk("after_drop_pr", 101, {63'd0, pipe_ready}, 64'd1);
        chk("after_drop_mr", 101, {63'd0, mdu_ready},  64'd0);
        @(posedge clk);
        #1;
        chk("after_drop_cnt", 101, {60'd0, starve_cnt}, 64'd1);
        chk("after_drop_addr", 101, {59'd0, rf_waddr}, 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stream and the long-latency multiply/divide unit (MDU) result stream. The pipeline has priority by default. A starvation counter forces an MDU grant after a bounded wait. The block sits after the writeback stage, and its registered outputs drive the regfile write port directly.

Parameters:
DATA_W, 64, width of write data
ADDR_W, 5, width of destination register index
STARVE_LIMIT, 4, consecutive stalled MDU cycles before the MDU is forced ahead of the pipeline; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pipe_valid  in  1  pipeline writeback request
pipe_dst  in  ADDR_W  pipeline destination register
pipe_data  in  DATA_W  pipeline write data
pipe_ready  out  1  pipeline request accepted this cycle (combinational)
mdu_valid  in  1  MDU result request
mdu_dst  in  ADDR_W  MDU destination register
mdu_data  in  DATA_W  MDU result
mdu_ready  out  1  MDU request accepted this cycle (combinational)
rf_wen  out  1  regfile write enable (registered)
rf_waddr  out  ADDR_W  regfile write address (registered)
rf_wdata  out  DATA_W  regfile write data (registered)
starve_cnt  out  4  current MDU wait count, for debug

Behaviour:
- Handshake:
  - A transfer occurs when valid && ready.
  - Each requester holds valid and its payload stable until ready. The arbiter does not check this.
- States: NORMAL and FORCE_MDU.
- NORMAL:
  - If pipe_valid, then pipe_ready=1.
  - mdu_ready = mdu_valid && !pipe_valid_effective.
- FORCE_MDU:
  - If mdu_valid, then mdu_ready=1.
  - pipe_ready = pipe_valid && !mdu_valid_effective.
- *_valid_effective = valid && dst!=0.
- x0 requests:
  - A request with dst==0 is always accepted in the same cycle (ready=1).
  - It never occupies the port and never produces rf_wen.
  - Consequently both requesters can be accepted in one cycle if at least one targets x0.
- Output register:
  - On the clock edge after an accepted non-x0 request: rf_wen=1, rf_waddr=dst, rf_wdata=data.
  - Otherwise rf_wen=0. rf_waddr and rf_wdata hold their previous values.
  - Latency from accept to write is 1 cycle. At most one non-x0 write occurs per cycle.
- Starvation counter starve_cnt:
  - Clears to 0 on any MDU accept, or when mdu_valid=0.
  - Increments by 1 when mdu_valid && !mdu_ready.
  - Saturates at STARVE_LIMIT.
- State transitions:
  - NORMAL -> FORCE_MDU when starve_cnt reaches STARVE_LIMIT. The transition is evaluated on the next-state value, so the force takes effect in the cycle after the limit-th stall.
  - FORCE_MDU -> NORMAL on the MDU accept.
  - FORCE_MDU -> NORMAL if mdu_valid drops. Dropping valid is illegal, but the arbiter must not lock.
- Same destination in the same cycle: the normal priority applies. The loser writes one or more cycles later. Ordering of the two writes is the issue logic's responsibility.
- Reset:
  - Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, starve_cnt=0, state=NORMAL.
  - While reset is high: pipe_ready=0 and mdu_ready=0.
  - Reset mid-stall discards the pending count. A write registered in the reset cycle is suppressed.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt [31:0]. It increments every cycle in which both requests are valid-effective, and wraps at 2^32.
  - Adds output force_cnt [31:0]. It increments on each NORMAL->FORCE_MDU transition.
  - Both reset to 0.
- Undefined: neither port exists, and no counter logic is generated.

Test Plan:
- Pipe-only write: pipe_valid=1, dst=5, data=0x1234 -> pipe_ready=1 in the same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234.
- Simultaneous requests: pipe dst=3 and mdu dst=7, both valid, with pipe_valid held -> pipe wins; starve_cnt counts 1,2,3,4; MDU is granted on the 5th cycle (STARVE_LIMIT=4); the write to reg 7 appears one cycle later; starve_cnt then returns to 0.
- x0 coexistence: pipe dst=0 and mdu dst=9, both valid -> both ready in the same cycle; exactly one write follows, rf_waddr=9.
- Both requests target x0 -> both accepted; rf_wen stays 0.
- Reset mid-stall: after starve_cnt=2, assert reset for 1 cycle -> starve_cnt=0, state NORMAL, rf_wen=0, both ready signals low during reset.
- With WB_ARB_PERF_EN, scenario 2 -> conflict_cnt=5 and force_cnt=1 after completion.
